// File: rtl/alt_eyemon_avmm2dprio_rmw_pkg.sv
// Shared encodings for the eye-monitor AVMM-to-DPRIO gasket:
// FSM states, DPRIO op codes, Avalon response codes and fixed widths.
package alt_eyemon_avmm2dprio_rmw_pkg;

  localparam int unsigned ST_W      = 3;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned RESP_W    = 2;
  localparam int unsigned REMAP_W   = 12;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_MERGE = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

  localparam logic [OP_W-1:0] OP_RD     = 2'd0;
  localparam logic [OP_W-1:0] OP_WR     = 2'd1;
  localparam logic [OP_W-1:0] OP_RMW_RD = 2'd2;
  localparam logic [OP_W-1:0] OP_RMW_WR = 2'd3;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  // True for the ops that drive the DPRIO read strobe
  function automatic logic op_is_read(input logic [OP_W-1:0] op);
    return (op == OP_RD) || (op == OP_RMW_RD);
  endfunction

endpackage

// File: rtl/alt_eyemon_avmm2dprio_rmw_if.sv
// AVMM slave + alt_dprio master signal bundle; names are from the gasket's point of view.
interface alt_eyemon_avmm2dprio_rmw_if
  import alt_eyemon_avmm2dprio_rmw_pkg::*;
#(
  parameter int unsigned AAW = 16,
  parameter int unsigned DW  = 16,
  parameter int unsigned DAW = 16
);

  logic [AAW-1:0]     i_avmm_address;
  logic               i_avmm_read;
  logic               i_avmm_write;
  logic [DW-1:0]      i_avmm_writedata;
  logic [DW-1:0]      i_avmm_writemask;
  logic [DW-1:0]      o_avmm_readdata;
  logic               o_avmm_waitrequest;
  logic [RESP_W-1:0]  o_avmm_response;
  logic [REMAP_W-1:0] i_remap_address;
  logic               i_dprio_busy;
  logic [DW-1:0]      i_dprio_in;
  logic               o_dprio_wren;
  logic               o_dprio_rden;
  logic [DAW-1:0]     o_dprio_addr;
  logic [DW-1:0]      o_dprio_data;

  modport slave (
    input  i_avmm_address, i_avmm_read, i_avmm_write, i_avmm_writedata, i_avmm_writemask,
    input  i_remap_address, i_dprio_busy, i_dprio_in,
    output o_avmm_readdata, o_avmm_waitrequest, o_avmm_response,
    output o_dprio_wren, o_dprio_rden, o_dprio_addr, o_dprio_data
  );

  modport master (
    output i_avmm_address, i_avmm_read, i_avmm_write, i_avmm_writedata, i_avmm_writemask,
    output i_remap_address, i_dprio_busy, i_dprio_in,
    input  o_avmm_readdata, o_avmm_waitrequest, o_avmm_response,
    input  o_dprio_wren, o_dprio_rden, o_dprio_addr, o_dprio_data
  );

endinterface

// File: rtl/alt_eyemon_timeout_cnt.sv
// Per-transaction busy timeout: cleared on ISSUE entry, counts while enabled,
// flags expiry in the cycle the count reaches TIMEOUT_CYCLES-1.
module alt_eyemon_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TO_CNT_WIDTH   = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  logic [TO_CNT_WIDTH-1:0] r_cnt;

  assign o_expire_c = i_en && (r_cnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire_c) begin
      r_cnt <= r_cnt + TO_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alt_eyemon_avmm2dprio_rmw.sv
// Eye-monitor AVMM slave to alt_dprio gasket: latches each request, runs it on DPRIO with
// optional masked read-modify-write, busy timeout, and an Avalon response code.
module alt_eyemon_avmm2dprio_rmw
  import alt_eyemon_avmm2dprio_rmw_pkg::*;
#(
  parameter int unsigned        AVMM_ADDR_WIDTH  = 16,
  parameter int unsigned        DATA_WIDTH       = 16,
  parameter int unsigned        DPRIO_ADDR_WIDTH = 16,
  parameter int unsigned        TIMEOUT_CYCLES   = 1023,
  parameter int unsigned        TO_CNT_WIDTH     = 10,
  parameter logic [REMAP_W-1:0] INVALID_CH       = 12'hfff,
  parameter bit                 RMW_EN           = 1'b1
) (
  input  logic                 i_avmm_clk,
  input  logic                 i_reset,
  alt_eyemon_avmm2dprio_rmw_if.slave bus,
  output logic                 o_timeout,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  logic [ST_W-1:0]             r_state;
  logic [OP_W-1:0]             r_op;
  logic [DPRIO_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]       r_wdata;
  logic [DATA_WIDTH-1:0]       r_mask;
  logic [DATA_WIDTH-1:0]       r_merge;
  logic [DATA_WIDTH-1:0]       r_dprio_data;
  logic                        r_rden;
  logic                        r_wren;
  logic [DATA_WIDTH-1:0]       r_readdata;
  logic [RESP_W-1:0]           r_resp;
  logic                        r_timeout;
  logic [ERR_CNT_W-1:0]        r_err_count;

  logic [ST_W-1:0]             w_state_nxt;
  logic [OP_W-1:0]             w_op_nxt;
  logic [DATA_WIDTH-1:0]       w_data_nxt;
  logic [DATA_WIDTH-1:0]       w_readdata_nxt;
  logic [RESP_W-1:0]           w_resp_nxt;
  logic                        w_rden_nxt;
  logic                        w_wren_nxt;
  logic                        w_timeout_nxt;
  logic                        w_err_inc;
  logic                        w_latch;
  logic                        w_merge_ld;
  logic                        w_req;
  logic [OP_W-1:0]             w_req_op;
  logic [DATA_WIDTH-1:0]       w_merged;
  logic [AVMM_ADDR_WIDTH-1:0]  w_avmm_addr;
  logic                        w_expire;
  logic                        w_to_clr;
  logic                        w_to_en;

  assign w_req       = bus.i_avmm_read | bus.i_avmm_write;
  assign w_avmm_addr = bus.i_avmm_address;
  assign w_merged    = (r_merge & ~r_mask) | (r_wdata & r_mask);

  // Read wins over write; a partial mask turns a write into read-modify-write
  assign w_req_op = bus.i_avmm_read                   ? OP_RD     :
                    (RMW_EN && ~&bus.i_avmm_writemask) ? OP_RMW_RD : OP_WR;

  assign w_to_clr = (w_state_nxt == ST_ISSUE) && (r_state != ST_ISSUE);
  assign w_to_en  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

  alt_eyemon_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_WIDTH   (TO_CNT_WIDTH)
  ) u_timeout_cnt (
    .i_clk      (i_avmm_clk),
    .i_rst      (i_reset),
    .i_clr      (w_to_clr),
    .i_en       (w_to_en),
    .o_expire_c (w_expire)
  );

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_data_nxt     = r_dprio_data;
    w_readdata_nxt = r_readdata;
    w_resp_nxt     = r_resp;
    w_timeout_nxt  = 1'b0;
    w_err_inc      = 1'b0;
    w_latch        = 1'b0;
    w_merge_ld     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_latch    = 1'b1;
          w_op_nxt   = w_req_op;
          w_data_nxt = bus.i_avmm_writedata;
          if (bus.i_remap_address == INVALID_CH) begin
            w_state_nxt    = ST_DONE;
            w_resp_nxt     = RESP_SLVERR;
            w_readdata_nxt = '0;
            w_err_inc      = 1'b1;
          end else if (!bus.i_dprio_busy) begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (w_expire) begin
          w_state_nxt    = ST_DONE;
          w_resp_nxt     = RESP_DECERR;
          w_readdata_nxt = '0;
          w_timeout_nxt  = 1'b1;
          w_err_inc      = 1'b1;
        end else if (bus.i_dprio_busy) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_expire) begin
          w_state_nxt    = ST_DONE;
          w_resp_nxt     = RESP_DECERR;
          w_readdata_nxt = '0;
          w_timeout_nxt  = 1'b1;
          w_err_inc      = 1'b1;
        end else if (!bus.i_dprio_busy) begin
          case (r_op)
            OP_RD: begin
              w_state_nxt    = ST_DONE;
              w_resp_nxt     = RESP_OKAY;
              w_readdata_nxt = bus.i_dprio_in;
            end
            OP_RMW_RD: begin
              w_state_nxt = ST_MERGE;
              w_merge_ld  = 1'b1;
            end
            default: begin
              w_state_nxt = ST_DONE;
              w_resp_nxt  = RESP_OKAY;
            end
          endcase
        end
      end
      ST_MERGE: begin
        w_state_nxt = ST_ISSUE;
        w_op_nxt    = OP_RMW_WR;
        w_data_nxt  = w_merged;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // Strobes are high exactly while the registered state is ISSUE
    w_rden_nxt = (w_state_nxt == ST_ISSUE) &&  op_is_read(w_op_nxt);
    w_wren_nxt = (w_state_nxt == ST_ISSUE) && !op_is_read(w_op_nxt);
  end

  always_ff @(posedge i_avmm_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_RD;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_merge      <= '0;
      r_dprio_data <= '0;
      r_rden       <= 1'b0;
      r_wren       <= 1'b0;
      r_readdata   <= '0;
      r_resp       <= RESP_OKAY;
      r_timeout    <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_dprio_data <= w_data_nxt;
      r_rden       <= w_rden_nxt;
      r_wren       <= w_wren_nxt;
      r_readdata   <= w_readdata_nxt;
      r_resp       <= w_resp_nxt;
      r_timeout    <= w_timeout_nxt;
      if (w_latch) begin
        r_addr  <= DPRIO_ADDR_WIDTH'(w_avmm_addr);
        r_wdata <= bus.i_avmm_writedata;
        r_mask  <= bus.i_avmm_writemask;
      end
      if (w_merge_ld) begin
        r_merge <= bus.i_dprio_in;
      end
      if (w_err_inc && (r_err_count != {ERR_CNT_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.o_avmm_waitrequest = w_req && (r_state != ST_DONE);
  assign bus.o_avmm_readdata    = r_readdata;
  assign bus.o_avmm_response    = r_resp;
  assign bus.o_dprio_rden       = r_rden;
  assign bus.o_dprio_wren       = r_wren;
  assign bus.o_dprio_addr       = r_addr;
  assign bus.o_dprio_data       = r_dprio_data;
  assign o_timeout              = r_timeout;
  assign o_err_count            = r_err_count;

endmodule

// File: tb/tb_alt_eyemon_avmm2dprio_rmw.sv
// Directed bench for alt_eyemon_avmm2dprio_rmw: table of AVMM transactions against a
// small alt_dprio responder, plus hand sequences for back-to-back, saturation and reset.
module tb_alt_eyemon_avmm2dprio_rmw;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_timeout;
  logic [7:0] tb_err_count;

  always #5 clk = ~clk;

  alt_eyemon_avmm2dprio_rmw_if #(.AAW(16), .DW(16), .DAW(16)) bus ();

  alt_eyemon_avmm2dprio_rmw #(
    .AVMM_ADDR_WIDTH  (16),
    .DATA_WIDTH       (16),
    .DPRIO_ADDR_WIDTH (16),
    .TIMEOUT_CYCLES   (8),
    .TO_CNT_WIDTH     (4),
    .INVALID_CH       (12'hfff),
    .RMW_EN           (1'b1)
  ) dut (
    .i_avmm_clk  (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_timeout   (tb_timeout),
    .o_err_count (tb_err_count)
  );

  // alt_dprio responder: busy rises the half-cycle after a strobe, lasts busy_len cycles
  int          busy_len = 1;
  logic        stuck    = 1'b0;
  logic [15:0] rd_ret   = '0;
  logic        busy_q   = 1'b0;
  int          remain   = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          to_cnt   = 0;
  logic [15:0] last_wdata = '0;
  logic [15:0] last_addr  = '0;

  assign bus.i_dprio_busy = busy_q;
  assign bus.i_dprio_in   = busy_q ? 16'h0000 : rd_ret;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      busy_q = 1'b0;
      remain = 0;
    end else begin
      if (bus.o_dprio_rden) begin
        rd_cnt++;
        last_addr = bus.o_dprio_addr;
      end
      if (bus.o_dprio_wren) begin
        wr_cnt++;
        last_wdata = bus.o_dprio_data;
        last_addr  = bus.o_dprio_addr;
      end
      if (tb_timeout) to_cnt++;
      if (busy_q) begin
        if (!stuck) begin
          if (remain == 0) busy_q = 1'b0;
          else remain--;
        end
      end else if (bus.o_dprio_rden || bus.o_dprio_wren) begin
        busy_q = 1'b1;
        remain = busy_len - 1;
      end
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wd;
    logic [15:0] mask;
    logic [11:0] remap;
    logic [15:0] ret;
    int          blen;
    logic        stk;
    logic        chk_rd;
    logic [15:0] e_rdata;
    logic [1:0]  e_resp;
    int          e_lat;
    int          e_rd;
    int          e_wr;
    logic [15:0] e_wd;
    int          e_err;
    int          e_to;
  } vec_t;

  vec_t vecs[11];
  int   total = 0;
  int   bad   = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [15:0] addr, input logic rd, input logic wr,
      input logic [15:0] wd, input logic [15:0] mask, input logic [11:0] remap,
      input logic [15:0] ret, input int blen, input logic stk, input logic chk_rd,
      input logic [15:0] e_rdata, input logic [1:0] e_resp, input int e_lat,
      input int e_rd, input int e_wr, input logic [15:0] e_wd, input int e_err, input int e_to);
    vec_t v;
    v.addr = addr; v.rd = rd; v.wr = wr; v.wd = wd; v.mask = mask; v.remap = remap;
    v.ret = ret; v.blen = blen; v.stk = stk; v.chk_rd = chk_rd; v.e_rdata = e_rdata;
    v.e_resp = e_resp; v.e_lat = e_lat; v.e_rd = e_rd; v.e_wr = e_wr; v.e_wd = e_wd;
    v.e_err = e_err; v.e_to = e_to;
    return v;
  endfunction

  // Drive one request, wait (bounded) for the DONE cycle, then release the bus
  task automatic run_txn(input vec_t v, output logic [15:0] rdata, output logic [1:0] resp,
      output int lat, output int nrd, output int nwr, output int nto, output logic [1:0] held,
      output bit done);
    int rd0, wr0, to0;
    for (int i = 0; i < 50 && busy_q; i++) @(negedge clk);
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt; to0 = to_cnt;
    busy_len = v.blen; stuck = v.stk; rd_ret = v.ret;
    bus.i_avmm_address   = v.addr;
    bus.i_avmm_read      = v.rd;
    bus.i_avmm_write     = v.wr;
    bus.i_avmm_writedata = v.wd;
    bus.i_avmm_writemask = v.mask;
    bus.i_remap_address  = v.remap;
    done = 1'b0; lat = 0; rdata = '0; resp = '0;
    while (!done && lat < 40) begin
      @(negedge clk); #1;
      lat++;
      if (!bus.o_avmm_waitrequest) begin
        done  = 1'b1;
        rdata = bus.o_avmm_readdata;
        resp  = bus.o_avmm_response;
      end
    end
    bus.i_avmm_read = 1'b0; bus.i_avmm_write = 1'b0; bus.i_remap_address = '0;
    stuck = 1'b0;
    @(negedge clk); #1;
    held = bus.o_avmm_response;
    nrd = rd_cnt - rd0; nwr = wr_cnt - wr0; nto = to_cnt - to0;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    logic [15:0] rdata; logic [1:0] resp, held; int lat, nrd, nwr, nto; bit done;
    string p;
    p = $sformatf("v%0d", idx);
    run_txn(v, rdata, resp, lat, nrd, nwr, nto, held, done);
    chk({p, "_done"}, int'(done), 1);
    if (v.chk_rd) chk({p, "_rdata"}, int'(rdata), int'(v.e_rdata));
    chk({p, "_resp"}, int'(resp), int'(v.e_resp));
    chk({p, "_resp_held"}, int'(held), int'(v.e_resp));
    chk({p, "_latency"}, lat, v.e_lat);
    chk({p, "_rden_cycles"}, nrd, v.e_rd);
    chk({p, "_wren_cycles"}, nwr, v.e_wr);
    if (v.e_wr > 0) chk({p, "_wdata"}, int'(last_wdata), int'(v.e_wd));
    if (v.e_rd + v.e_wr > 0) chk({p, "_addr"}, int'(last_addr), int'(v.addr));
    chk({p, "_timeout_pulses"}, nto, v.e_to);
    exp_err = (exp_err + v.e_err > 255) ? 255 : exp_err + v.e_err;
    chk({p, "_err_count"}, int'(tb_err_count), exp_err);
  endtask

  initial begin
    logic [15:0] rdata; logic [1:0] resp, held; int lat, nrd, nwr, nto, wl, rd0; bit done;
    //            addr     rd wr wd       mask     remap    ret      bl st ck e_rdata  rsp   lat rd wr e_wd     err to
    vecs[0]  = mkv(16'h0123, 1, 0, 16'h0000, 16'hFFFF, 12'h001, 16'hBEEF, 3, 0, 1, 16'hBEEF, 2'b00, 5, 1, 0, 16'h0000, 0, 0);
    vecs[1]  = mkv(16'h0200, 0, 1, 16'h00F0, 16'h00FF, 12'h002, 16'hAB12, 1, 0, 0, 16'h0000, 2'b00, 6, 1, 1, 16'hABF0, 0, 0);
    vecs[2]  = mkv(16'h0300, 0, 1, 16'h1234, 16'hFFFF, 12'h003, 16'h0000, 1, 0, 0, 16'h0000, 2'b00, 3, 0, 1, 16'h1234, 0, 0);
    vecs[3]  = mkv(16'h0400, 1, 0, 16'h0000, 16'hFFFF, 12'hFFF, 16'h1111, 1, 0, 1, 16'h0000, 2'b10, 1, 0, 0, 16'h0000, 1, 0);
    vecs[4]  = mkv(16'h0500, 1, 0, 16'h0000, 16'hFFFF, 12'h005, 16'h5A5A, 1, 0, 1, 16'h5A5A, 2'b00, 3, 1, 0, 16'h0000, 0, 0);
    vecs[5]  = mkv(16'h0600, 1, 1, 16'h9999, 16'hFFFF, 12'h006, 16'h0F0F, 1, 0, 1, 16'h0F0F, 2'b00, 3, 1, 0, 16'h0000, 0, 0);
    vecs[6]  = mkv(16'h0700, 0, 1, 16'h5555, 16'h00FF, 12'hFFF, 16'h0000, 1, 0, 0, 16'h0000, 2'b10, 1, 0, 0, 16'h0000, 1, 0);
    vecs[7]  = mkv(16'h0800, 0, 1, 16'hFFFF, 16'h0000, 12'h008, 16'h1357, 1, 0, 0, 16'h0000, 2'b00, 6, 1, 1, 16'h1357, 0, 0);
    vecs[8]  = mkv(16'h0900, 0, 1, 16'h1234, 16'hF0F0, 12'h009, 16'hABCD, 2, 0, 0, 16'h0000, 2'b00, 8, 1, 1, 16'h1B3D, 0, 0);
    vecs[9]  = mkv(16'h0A00, 1, 0, 16'h0000, 16'hFFFF, 12'h00A, 16'h2222, 1, 1, 1, 16'h0000, 2'b11, 9, 1, 0, 16'h0000, 1, 1);
    vecs[10] = mkv(16'h0B00, 1, 0, 16'h0000, 16'hFFFF, 12'h00B, 16'h4242, 1, 0, 1, 16'h4242, 2'b00, 3, 1, 0, 16'h0000, 0, 0);

    bus.i_avmm_address = '0; bus.i_avmm_read = 1'b0; bus.i_avmm_write = 1'b0;
    bus.i_avmm_writedata = '0; bus.i_avmm_writemask = '1; bus.i_remap_address = '0;
    #1;
    chk("reset_waitrequest", int'(bus.o_avmm_waitrequest), 0);
    chk("reset_rden", int'(bus.o_dprio_rden), 0);
    chk("reset_wren", int'(bus.o_dprio_wren), 0);
    chk("reset_resp", int'(bus.o_avmm_response), 0);
    chk("reset_readdata", int'(bus.o_avmm_readdata), 0);
    chk("reset_err_count", int'(tb_err_count), 0);
    chk("reset_timeout", int'(tb_timeout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) check_vec(vecs[i], i);

    // Saturate the error counter with back-to-back invalid-channel reads
    for (int i = 0; i < 260; i++) run_txn(vecs[3], rdata, resp, lat, nrd, nwr, nto, held, done);
    chk("err_count_saturated", int'(tb_err_count), 255);

    // Read held high through DONE: one low waitrequest cycle per transaction, then re-issue
    @(negedge clk);
    busy_len = 1; rd_ret = 16'h7777;
    bus.i_avmm_address = 16'h0D00; bus.i_remap_address = 12'h00D; bus.i_avmm_read = 1'b1;
    rd0 = rd_cnt; wl = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (!bus.o_avmm_waitrequest) wl++;
    end
    bus.i_avmm_read = 1'b0; bus.i_remap_address = '0;
    chk("held_read_wait_low_cycles", wl, 3);
    chk("held_read_rden_count", rd_cnt - rd0, 3);
    chk("held_read_rdata", int'(bus.o_avmm_readdata), 16'h7777);

    // Reset in WAIT of a read-modify-write clears everything asynchronously
    @(negedge clk);
    busy_len = 6; rd_ret = 16'hCAFE;
    bus.i_avmm_address = 16'h0C00; bus.i_remap_address = 12'h00C;
    bus.i_avmm_writedata = 16'h00F0; bus.i_avmm_writemask = 16'h00FF; bus.i_avmm_write = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rden", int'(bus.o_dprio_rden), 0);
    chk("midrst_wren", int'(bus.o_dprio_wren), 0);
    chk("midrst_err_count", int'(tb_err_count), 0);
    chk("midrst_readdata", int'(bus.o_avmm_readdata), 0);
    chk("midrst_waitrequest", int'(bus.o_avmm_waitrequest), 1);
    @(negedge clk);
    bus.i_avmm_write = 1'b0; bus.i_remap_address = '0; bus.i_avmm_writemask = '1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    check_vec(vecs[4], 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
